// File: rtl/synth_voice_scheduler.sv
// Voice allocator and shadow-parameter store for the synth, publishing snapshots
// to the CPU->synth CDC through a 4-phase req/ack handshake with update coalescing.
module synth_voice_scheduler #(
    parameter int N_VOICES = 4,
    localparam int VW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [23:0]             cmd_fcw,
    input  logic [4:0]              cmd_shift,
    output logic                    resp_valid,
    output logic [VW-1:0]           resp_voice,
    output logic                    resp_hit,
    output logic [24*N_VOICES-1:0]  cpu_carrier_fcws,
    output logic [23:0]             cpu_mod_fcw,
    output logic [4:0]              cpu_mod_shift,
    output logic [N_VOICES-1:0]     cpu_note_en,
    output logic [4:0]              cpu_synth_shift,
    output logic                    cpu_req,
    input  logic                    cpu_ack
);

    localparam logic [1:0] OP_NOTE_ON   = 2'b00;
    localparam logic [1:0] OP_NOTE_OFF  = 2'b01;
    localparam logic [1:0] OP_SET_MOD   = 2'b10;
    localparam logic [1:0] OP_SET_SHIFT = 2'b11;
    localparam logic [VW-1:0] LAST_VOICE = VW'(N_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } hs_state_t;

    hs_state_t state_reg, state_next;

    // Shadow copy of synth parameters
    logic [23:0]         voice_fcw_reg  [N_VOICES];
    logic [23:0]         voice_fcw_next [N_VOICES];
    logic [N_VOICES-1:0] voice_en_reg, voice_en_next;
    logic [23:0]         mod_fcw_reg, mod_fcw_next;
    logic [4:0]          mod_shift_reg, mod_shift_next;
    logic [4:0]          synth_shift_reg, synth_shift_next;
    logic [VW-1:0]       sp_reg, sp_next;
    logic                dirty_reg, dirty_next;

    // Snapshot presented to the CDC
    logic [23:0]         snap_fcw_reg [N_VOICES];
    logic [N_VOICES-1:0] snap_en_reg;
    logic [23:0]         snap_mod_fcw_reg;
    logic [4:0]          snap_mod_shift_reg;
    logic [4:0]          snap_synth_shift_reg;
    logic                cpu_req_reg;

    logic                resp_valid_reg;
    logic [VW-1:0]       resp_voice_reg, resp_voice_next;
    logic                resp_hit_reg, resp_hit_next;

    logic                accept;
    logic                changed;
    logic                snap_load;
    logic [N_VOICES-1:0] match_vec;
    logic [N_VOICES-1:0] free_vec;
    logic                match_any;
    logic                free_any;
    logic [VW-1:0]       match_idx;
    logic [VW-1:0]       free_idx;

    assign cmd_ready = !rst;
    assign accept    = cmd_valid && !rst;

    for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_voice
        assign match_vec[gi] = voice_en_reg[gi] && (voice_fcw_reg[gi] == cmd_fcw);
        assign free_vec[gi]  = !voice_en_reg[gi];
        assign cpu_carrier_fcws[24*gi +: 24] = snap_fcw_reg[gi];
    end

    assign match_any = |match_vec;
    assign free_any  = |free_vec;

    // Lowest-index priority encoders: scan downward so the lowest hit wins
    always_comb begin
        match_idx = '0;
        free_idx  = '0;
        for (int i = N_VOICES - 1; i >= 0; i--) begin
            if (match_vec[i]) match_idx = VW'(i);
            if (free_vec[i])  free_idx  = VW'(i);
        end
    end

    always_comb begin
        voice_fcw_next   = voice_fcw_reg;
        voice_en_next    = voice_en_reg;
        mod_fcw_next     = mod_fcw_reg;
        mod_shift_next   = mod_shift_reg;
        synth_shift_next = synth_shift_reg;
        sp_next          = sp_reg;
        resp_voice_next  = '0;
        resp_hit_next    = 1'b0;
        changed          = 1'b0;
        if (accept) begin
            case (cmd_op)
                OP_NOTE_ON: begin
                    if (match_any) begin
                        resp_voice_next = match_idx;
                        resp_hit_next   = 1'b1;
                    end else if (free_any) begin
                        voice_fcw_next[free_idx] = cmd_fcw;
                        voice_en_next[free_idx]  = 1'b1;
                        resp_voice_next          = free_idx;
                        changed                  = 1'b1;
                    end else begin
                        voice_fcw_next[sp_reg] = cmd_fcw;
                        resp_voice_next        = sp_reg;
                        resp_hit_next          = 1'b1;
                        changed                = 1'b1;
                        sp_next = (sp_reg == LAST_VOICE) ? '0 : sp_reg + 1'b1;
                    end
                end
                OP_NOTE_OFF: begin
                    voice_en_next   = voice_en_reg & ~match_vec;
                    resp_voice_next = match_idx;
                    resp_hit_next   = match_any;
                    changed         = match_any;
                end
                OP_SET_MOD: begin
                    mod_fcw_next   = cmd_fcw;
                    mod_shift_next = cmd_shift;
                    changed        = 1'b1;
                end
                default: begin
                    synth_shift_next = cmd_shift;
                    changed          = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        snap_load  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (dirty_reg && !cpu_ack) begin
                    snap_load  = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cpu_ack) state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!cpu_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // A command landing with the snapshot keeps dirty so it ships next time
        dirty_next = changed ? 1'b1 : (snap_load ? 1'b0 : dirty_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= ST_IDLE;
            voice_en_reg         <= '0;
            mod_fcw_reg          <= '0;
            mod_shift_reg        <= '0;
            synth_shift_reg      <= '0;
            sp_reg               <= '0;
            dirty_reg            <= 1'b0;
            snap_en_reg          <= '0;
            snap_mod_fcw_reg     <= '0;
            snap_mod_shift_reg   <= '0;
            snap_synth_shift_reg <= '0;
            cpu_req_reg          <= 1'b0;
            resp_valid_reg       <= 1'b0;
            resp_voice_reg       <= '0;
            resp_hit_reg         <= 1'b0;
            for (int i = 0; i < N_VOICES; i++) begin
                voice_fcw_reg[i] <= '0;
                snap_fcw_reg[i]  <= '0;
            end
        end else begin
            state_reg       <= state_next;
            voice_fcw_reg   <= voice_fcw_next;
            voice_en_reg    <= voice_en_next;
            mod_fcw_reg     <= mod_fcw_next;
            mod_shift_reg   <= mod_shift_next;
            synth_shift_reg <= synth_shift_next;
            sp_reg          <= sp_next;
            dirty_reg       <= dirty_next;
            cpu_req_reg     <= (state_next == ST_REQ);
            resp_valid_reg  <= accept;
            resp_voice_reg  <= resp_voice_next;
            resp_hit_reg    <= resp_hit_next;
            if (snap_load) begin
                snap_fcw_reg         <= voice_fcw_reg;
                snap_en_reg          <= voice_en_reg;
                snap_mod_fcw_reg     <= mod_fcw_reg;
                snap_mod_shift_reg   <= mod_shift_reg;
                snap_synth_shift_reg <= synth_shift_reg;
            end
        end
    end

    assign resp_valid      = resp_valid_reg;
    assign resp_voice      = resp_voice_reg;
    assign resp_hit        = resp_hit_reg;
    assign cpu_note_en     = snap_en_reg;
    assign cpu_mod_fcw     = snap_mod_fcw_reg;
    assign cpu_mod_shift   = snap_mod_shift_reg;
    assign cpu_synth_shift = snap_synth_shift_reg;
    assign cpu_req         = cpu_req_reg;

endmodule

// File: tb/tb_synth_voice_scheduler.sv
// Directed bench for synth_voice_scheduler: allocation, stealing, reuse,
// coalesced handshakes and reset mid-transfer, with hand-computed expectations.
module tb_synth_voice_scheduler;

    localparam int N_VOICES = 4;
    localparam int VW = 2;

    logic                   clk;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [23:0]            cmd_fcw;
    logic [4:0]             cmd_shift;
    logic                   resp_valid;
    logic [VW-1:0]          resp_voice;
    logic                   resp_hit;
    logic [24*N_VOICES-1:0] cpu_carrier_fcws;
    logic [23:0]            cpu_mod_fcw;
    logic [4:0]             cpu_mod_shift;
    logic [N_VOICES-1:0]    cpu_note_en;
    logic [4:0]             cpu_synth_shift;
    logic                   cpu_req;
    logic                   cpu_ack;

    int n_tests = 0;
    int n_fail  = 0;

    synth_voice_scheduler #(.N_VOICES(N_VOICES)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_fcw          (cmd_fcw),
        .cmd_shift        (cmd_shift),
        .resp_valid       (resp_valid),
        .resp_voice       (resp_voice),
        .resp_hit         (resp_hit),
        .cpu_carrier_fcws (cpu_carrier_fcws),
        .cpu_mod_fcw      (cpu_mod_fcw),
        .cpu_mod_shift    (cpu_mod_shift),
        .cpu_note_en      (cpu_note_en),
        .cpu_synth_shift  (cpu_synth_shift),
        .cpu_req          (cpu_req),
        .cpu_ack          (cpu_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [23:0] fcw, input logic [4:0] sh);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_fcw   = fcw;
        cmd_shift = sh;
        tick();
        cmd_valid = 1'b0;
        $display("[TB] cmd op=%0d fcw=0x%06h shift=%0d -> resp_valid=%0b voice=%0d hit=%0b",
                 op, fcw, sh, resp_valid, resp_voice, resp_hit);
    endtask

    // Wait (bounded) for cpu_req, then acknowledge and release; ends with FSM in IDLE
    task automatic complete_xfer(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (cpu_req) break;
            tick();
        end
        check({tag, "_req_rise"}, cpu_req, 1'b1);
        cpu_ack = 1'b1;
        tick();
        check({tag, "_req_drop"}, cpu_req, 1'b0);
        cpu_ack = 1'b0;
        tick();
        $display("[TB] xfer %s note_en=%b synth_shift=%0d", tag, cpu_note_en, cpu_synth_shift);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_fcw   = '0;
        cmd_shift = '0;
        cpu_ack   = 1'b0;
        tick();
        tick();
        check("ready_in_reset", cmd_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", cmd_ready, 1'b1);
        check("reset_req", cpu_req, 1'b0);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_note_en", cpu_note_en, 4'h0);
        check("reset_fcws", cpu_carrier_fcws, 96'h0);
        check("reset_synth_shift", cpu_synth_shift, 5'd0);

        // First note: free voice 0, request two cycles after acceptance
        do_cmd(2'b00, 24'h001000, 5'd0);
        check("on1_valid", resp_valid, 1'b1);
        check("on1_voice", resp_voice, 2'd0);
        check("on1_hit", resp_hit, 1'b0);
        check("on1_req_not_yet", cpu_req, 1'b0);
        tick();
        check("on1_valid_pulse", resp_valid, 1'b0);
        check("on1_req", cpu_req, 1'b1);
        check("on1_note_en", cpu_note_en, 4'b0001);
        check("on1_fcw0", cpu_carrier_fcws[23:0], 24'h001000);
        cpu_ack = 1'b1;
        tick();
        check("on1_req_low_on_ack", cpu_req, 1'b0);
        cpu_ack = 1'b0;
        tick();
        tick();
        check("on1_idle_no_req", cpu_req, 1'b0);

        // Fill remaining voices back to back; updates coalesce into two transfers
        do_cmd(2'b00, 24'h002000, 5'd0);
        check("on2_voice", resp_voice, 2'd1);
        do_cmd(2'b00, 24'h003000, 5'd0);
        check("on3_voice", resp_voice, 2'd2);
        do_cmd(2'b00, 24'h004000, 5'd0);
        check("on4_voice", resp_voice, 2'd3);
        check("on4_hit", resp_hit, 1'b0);
        complete_xfer("xa");
        complete_xfer("xb");
        check("full_note_en", cpu_note_en, 4'hF);
        check("full_fcws", cpu_carrier_fcws, {24'h004000, 24'h003000, 24'h002000, 24'h001000});
        tick();
        tick();
        check("full_no_extra_req", cpu_req, 1'b0);

        // Steal voice 0, then voice 1
        do_cmd(2'b00, 24'h00ABCD, 5'd0);
        check("steal0_voice", resp_voice, 2'd0);
        check("steal0_hit", resp_hit, 1'b1);
        complete_xfer("xs0");
        check("steal0_fcw", cpu_carrier_fcws[23:0], 24'h00ABCD);
        check("steal0_note_en", cpu_note_en, 4'hF);
        do_cmd(2'b00, 24'h00BEEF, 5'd0);
        check("steal1_voice", resp_voice, 2'd1);
        check("steal1_hit", resp_hit, 1'b1);
        complete_xfer("xs1");
        check("steal1_fcw", cpu_carrier_fcws[47:24], 24'h00BEEF);

        // Reuse of a playing FCW: no shadow change, no transfer
        do_cmd(2'b00, 24'h003000, 5'd0);
        check("reuse_voice", resp_voice, 2'd2);
        check("reuse_hit", resp_hit, 1'b1);
        tick();
        tick();
        tick();
        check("reuse_no_req", cpu_req, 1'b0);

        // Coalescing: SET_SHIFT lands with the snapshot edge, NOTE_OFF during REQ
        do_cmd(2'b10, 24'h012345, 5'd3);
        do_cmd(2'b11, 24'h000000, 5'd7);
        check("coal_req_up", cpu_req, 1'b1);
        do_cmd(2'b01, 24'h00ABCD, 5'd0);
        check("coal_off_voice", resp_voice, 2'd0);
        check("coal_off_hit", resp_hit, 1'b1);
        check("coal_mod_fcw", cpu_mod_fcw, 24'h012345);
        check("coal_mod_shift", cpu_mod_shift, 5'd3);
        check("coal_shift_held", cpu_synth_shift, 5'd0);
        check("coal_en_held", cpu_note_en, 4'hF);
        complete_xfer("xc");
        complete_xfer("xd");
        check("coal_shift_new", cpu_synth_shift, 5'd7);
        check("coal_en_new", cpu_note_en, 4'hE);
        tick();
        tick();
        check("coal_single_followup", cpu_req, 1'b0);

        // NOTE_OFF of an absent FCW
        do_cmd(2'b01, 24'h0FFFFF, 5'd0);
        check("off_absent_hit", resp_hit, 1'b0);
        check("off_absent_voice", resp_voice, 2'd0);
        tick();
        tick();
        tick();
        check("off_absent_no_req", cpu_req, 1'b0);

        // Reset while in REQ
        do_cmd(2'b11, 24'h000000, 5'd9);
        tick();
        check("rst_pre_req", cpu_req, 1'b1);
        rst = 1'b1;
        tick();
        check("rst_req", cpu_req, 1'b0);
        check("rst_shift", cpu_synth_shift, 5'd0);
        check("rst_note_en", cpu_note_en, 4'h0);
        check("rst_fcws", cpu_carrier_fcws, 96'h0);
        check("rst_mod_fcw", cpu_mod_fcw, 24'h0);
        check("rst_resp_valid", resp_valid, 1'b0);
        rst = 1'b0;
        do_cmd(2'b00, 24'h005000, 5'd0);
        check("post_rst_voice", resp_voice, 2'd0);
        check("post_rst_hit", resp_hit, 1'b0);
        tick();
        check("post_rst_req", cpu_req, 1'b1);
        check("post_rst_note_en", cpu_note_en, 4'b0001);
        check("post_rst_fcw0", cpu_carrier_fcws[23:0], 24'h005000);
        complete_xfer("xr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
